earlgrey_rst_seq: RTL and testbench
===================================

# earlgrey_rst_seq

Reset sequencer between the board clock generator and the Earl Grey top. It holds system and USB resets asserted until the PLL is locked and every reset request has gone away. It then releases the system reset, and later the USB reset, as a timed staggered sequence. It also records why the last reset happened, and re-enters reset on any new request or loss of PLL lock.

## Interface
- `HoldCycles`, 16: cycles of clean conditions required before releasing `rst_sys_no`; legal range 1..2^CntW-1.
- `UsbDelay`, 8: cycles from `rst_sys_no` release to `rst_usb_no` release; legal range 1..2^CntW-1.
- `LockTimeout`, 1024: unlocked cycles in ASSERT before a PLL retry (watchdog only).
- `CntW`, 16: width of the shared down-counter.

Ports:
- `clk_i` in 1: system clock, free-running from the board oscillator.
- `rst_i` in 1: reset, synchronous, active-high.
- `pll_locked_i` in 1: PLL lock, already synchronized to `clk_i`.
- `ext_rst_req_i` in 1: board reset button, synchronized, active-high level.
- `jtag_srst_req_i` in 1: JTAG system-reset request, synchronized, active-high level.
- `sw_rst_req_i` in 1: software reset request, single-cycle pulse.
- `cause_clr_i` in 1: clears `rst_cause_o`, single-cycle pulse.
- `rst_sys_no` out 1: active-low reset to the Earl Grey top.
- `rst_usb_no` out 1: active-low reset to the USB 48 MHz domain, synchronized at the destination.
- `rst_cause_o` out 4: sticky cause bits. {lock loss, sw, jtag, ext} = bits [3:0].
- `state_o` out 2: current state encoding.
- `pll_rst_o` out 1: PLL reset pulse (watchdog only).
- `lock_err_o` out 1: sticky lock-timeout flag (watchdog only).

## Operation
- State encoding: ASSERT=0, HOLD=1, REL_SYS=2, RUN=3.
- Every output is a flop; nothing is driven combinationally from inputs.
- `clean` = `pll_locked_i & ~ext_rst_req_i & ~jtag_srst_req_i & ~sw_rst_req_i`.
- `trip` = `~clean`, evaluated in HOLD, REL_SYS and RUN.

State behaviour:
- ASSERT: `rst_sys_no`=0, `rst_usb_no`=0. When `clean`, load the counter with HoldCycles-1 and go to HOLD.
- HOLD: resets stay asserted; counter decrements. `trip` goes to ASSERT. Counter==0 with `clean` goes to REL_SYS and loads UsbDelay-1.
- REL_SYS: `rst_sys_no`=1, `rst_usb_no`=0; counter decrements. `trip` goes to ASSERT. Counter==0 goes to RUN.
- RUN: both resets deasserted. `trip` goes to ASSERT.

Reset outputs:
- `rst_sys_no` and `rst_usb_no` are registered together with the next state, so they change in the same cycle `state_o` does.
- On entry to ASSERT both resets drop in that cycle; the USB reset is never released before the system reset.

Cause capture (`rst_cause_o`):
- On any `trip`, OR these bits into the register: {~pll_locked_i, sw_rst_req_i, jtag_srst_req_i, ext_rst_req_i}.
- Trips out of HOLD are recorded too.
- `cause_clr_i` zeroes the register. If a `trip` lands in the same cycle, the new bits are set; set wins over clear.
- Causes are not captured in ASSERT or on `rst_i`.

Reset values:
- On `rst_i`: state=ASSERT, counter=0, `rst_sys_no`=0, `rst_usb_no`=0, `rst_cause_o`=0, `pll_rst_o`=0, `lock_err_o`=0.
- `rst_i` asserted mid-sequence returns to ASSERT on the next edge and does not log a cause.

## Timing
- `clean` first sampled high in ASSERT at edge t: HOLD at t+1, `rst_sys_no` rises at t+HoldCycles+1, `rst_usb_no` rises at t+HoldCycles+UsbDelay+1.
- `trip` sampled at edge t in HOLD, REL_SYS or RUN: state=ASSERT with both resets low after edge t+1. Exactly one cycle of latency.
- A `sw_rst_req_i` pulse restarts the full sequence: ASSERT lasts at least 1 cycle, then HOLD.
- If a level request persists, the block stays in ASSERT.
- Counter never wraps; it is reloaded on every state entry that uses it.

## Configuration
`RSTSEQ_LOCK_WDOG_EN`

Defined:
- In ASSERT, the counter counts unlocked cycles; locked cycles reset it.
- At LockTimeout consecutive unlocked cycles: `pll_rst_o`=1 for 4 cycles, `lock_err_o` is set (sticky until `rst_i`), the counter reloads and counting resumes.

Undefined:
- `pll_rst_o` and `lock_err_o` are tied 0.
- ASSERT waits for lock indefinitely.

## Test plan
- Power-on: `rst_i` for 3 cycles, `pll_locked_i`=1, no requests, HoldCycles=16, UsbDelay=8 -> `rst_sys_no` rises 17 cycles after the first ASSERT edge with `clean`, `rst_usb_no` 8 cycles later; `rst_cause_o`=0.
- In RUN, `sw_rst_req_i` pulse -> both resets low after 1 cycle; `rst_cause_o`=4'b0100; full sequence repeats.
- In HOLD at counter=5, `jtag_srst_req_i` high for 10 cycles -> ASSERT; `rst_cause_o[1]`=1; `rst_sys_no` stays 0 until 17 cycles after the request drops.
- `pll_locked_i` drops in REL_SYS -> `rst_sys_no` low after 1 cycle; `rst_cause_o[3]`=1; same-cycle `cause_clr_i` with an `ext_rst_req_i` trip -> `rst_cause_o`=4'b0001.
- With `RSTSEQ_LOCK_WDOG_EN`, LockTimeout=32, lock held low -> `pll_rst_o` pulses for 4 cycles every 32 cycles; `lock_err_o`=1; lock rising resumes the normal sequence.

Source files
------------

// File: rtl/earlgrey_rst_seq.sv
// earlgrey_rst_seq: holds the Earl Grey system and USB resets until the PLL
// is locked and all reset requests are gone, then releases them as a timed,
// staggered sequence. Records the cause of every re-entry into reset.
// Optional PLL lock watchdog: define RSTSEQ_LOCK_WDOG_EN.
module earlgrey_rst_seq #(
  parameter int unsigned HoldCycles  = 16,
  parameter int unsigned UsbDelay    = 8,
  parameter int unsigned LockTimeout = 1024,
  parameter int unsigned CntW        = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       ext_rst_req_i,
  input  logic       jtag_srst_req_i,
  input  logic       sw_rst_req_i,
  input  logic       cause_clr_i,
  output logic       rst_sys_no,
  output logic       rst_usb_no,
  output logic [3:0] rst_cause_o,
  output logic [1:0] state_o,
  output logic       pll_rst_o,
  output logic       lock_err_o
);

  typedef enum logic [1:0] {
    StAssert = 2'd0,
    StHold   = 2'd1,
    StRelSys = 2'd2,
    StRun    = 2'd3
  } state_e;

  localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] UsbLoad  = CntW'(UsbDelay - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rst_sys_q, rst_sys_d;
  logic            rst_usb_q, rst_usb_d;
  logic [3:0]      cause_q, cause_d;
  logic            clean, trip;
  logic [3:0]      cause_bits;
  logic            wdog_fire;

  assign clean      = pll_locked_i & ~ext_rst_req_i & ~jtag_srst_req_i & ~sw_rst_req_i;
  assign trip       = ~clean;
  assign cause_bits = {~pll_locked_i, sw_rst_req_i, jtag_srst_req_i, ext_rst_req_i};

  // Next state, shared counter, reset outputs and cause capture.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = cnt_q;
    wdog_fire = 1'b0;
    // Clear is applied first so a same-cycle trip can OR its bits back in.
    cause_d   = cause_clr_i ? 4'b0000 : cause_q;

    case (state_q)
      StAssert: begin
        if (clean) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = '0;
`ifdef RSTSEQ_LOCK_WDOG_EN
          // Count consecutive unlocked cycles; any locked cycle restarts the count.
          if (!pll_locked_i) begin
            if (cnt_q == CntW'(LockTimeout - 1)) wdog_fire = 1'b1;
            else                                 cnt_d = cnt_q + 1'b1;
          end
`endif
        end
      end
      StHold: begin
        if (trip) begin
          state_d = StAssert;
          cnt_d   = '0;
          cause_d = cause_d | cause_bits;
        end else if (cnt_q == '0) begin
          state_d = StRelSys;
          cnt_d   = UsbLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRelSys: begin
        if (trip) begin
          state_d = StAssert;
          cnt_d   = '0;
          cause_d = cause_d | cause_bits;
        end else if (cnt_q == '0) begin
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StRun: begin
        if (trip) begin
          state_d = StAssert;
          cnt_d   = '0;
          cause_d = cause_d | cause_bits;
        end
      end
      default: state_d = StAssert;
    endcase

    // Resets are registered alongside the state so they move in the same cycle.
    rst_sys_d = (state_d == StRelSys) || (state_d == StRun);
    rst_usb_d = (state_d == StRun);
  end

  // Sequencer state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      rst_sys_q <= 1'b0;
      rst_usb_q <= 1'b0;
      cause_q   <= 4'b0000;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_sys_q <= rst_sys_d;
      rst_usb_q <= rst_usb_d;
      cause_q   <= cause_d;
    end
  end

  assign state_o     = state_q;
  assign rst_sys_no  = rst_sys_q;
  assign rst_usb_no  = rst_usb_q;
  assign rst_cause_o = cause_q;

`ifdef RSTSEQ_LOCK_WDOG_EN
  logic [2:0] pls_q, pls_d;
  logic       pll_rst_q, pll_rst_d;
  logic       lock_err_q, lock_err_d;

  // PLL reset pulse stretcher (4 cycles) and sticky lock-timeout flag.
  always_comb begin
    pls_d = pls_q;
    if (wdog_fire)           pls_d = 3'd4;
    else if (pls_q != 3'd0)  pls_d = pls_q - 1'b1;
    pll_rst_d  = (pls_d != 3'd0);
    lock_err_d = lock_err_q | wdog_fire;
  end

  // Watchdog registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pls_q      <= 3'd0;
      pll_rst_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      pls_q      <= pls_d;
      pll_rst_q  <= pll_rst_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign pll_rst_o  = pll_rst_q;
  assign lock_err_o = lock_err_q;
`else
  // Without the watchdog, ASSERT simply waits for lock.
  logic unused_wdog;
  assign unused_wdog = ^LockTimeout ^ wdog_fire;
  assign pll_rst_o   = 1'b0;
  assign lock_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_earlgrey_rst_seq.sv
// Scoreboard bench for earlgrey_rst_seq: stimulus pushes expected output
// changes (cycle + value) into a queue; a monitor pops one entry every time
// the sampled outputs change and compares both the cycle and the value.
module tb_earlgrey_rst_seq;

  localparam int unsigned Hold   = 16;
  localparam int unsigned Usb    = 8;
  localparam int unsigned LockTo = 32;

  localparam logic [1:0] S_ASSERT = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REL    = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       sys;
    logic       usb;
    logic [3:0] cause;
    logic       pll;
    logic       err;
  } out_t;

  typedef struct {
    int   cyc;
    out_t v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i, pll_locked_i, ext_rst_req_i, jtag_srst_req_i;
  logic       sw_rst_req_i, cause_clr_i;
  logic       rst_sys_no, rst_usb_no, pll_rst_o, lock_err_o;
  logic [3:0] rst_cause_o;
  logic [1:0] state_o;

  earlgrey_rst_seq #(
    .HoldCycles (Hold),
    .UsbDelay   (Usb),
    .LockTimeout(LockTo),
    .CntW       (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pll_locked_i   (pll_locked_i),
    .ext_rst_req_i  (ext_rst_req_i),
    .jtag_srst_req_i(jtag_srst_req_i),
    .sw_rst_req_i   (sw_rst_req_i),
    .cause_clr_i    (cause_clr_i),
    .rst_sys_no     (rst_sys_no),
    .rst_usb_no     (rst_usb_no),
    .rst_cause_o    (rst_cause_o),
    .state_o        (state_o),
    .pll_rst_o      (pll_rst_o),
    .lock_err_o     (lock_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0;
  int         n_pass   = 0;
  exp_t       exp_q[$];
  logic [3:0] exp_cause = 4'b0000;
  logic       exp_err   = 1'b0;
  string      phase     = "reset";

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
  endtask

  task automatic push(input int c, input logic [1:0] st, input logic sys, input logic usb,
                      input logic pll);
    exp_t e;
    e.cyc = c;
    e.v   = '{st: st, sys: sys, usb: usb, cause: exp_cause, pll: pll, err: exp_err};
    exp_q.push_back(e);
  endtask

  // Clean conditions from cycle t onward: HOLD, REL_SYS and (optionally) RUN.
  task automatic seq_from(input int t, input bit full);
    push(t + 1, S_HOLD, 1'b0, 1'b0, 1'b0);
    push(t + Hold + 1, S_REL, 1'b1, 1'b0, 1'b0);
    if (full) push(t + Hold + Usb + 1, S_RUN, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every observed change of the outputs consumes one expectation.
  initial begin
    out_t cur, prev;
    exp_t e;
    bit   first = 1'b1;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{st: state_o, sys: rst_sys_no, usb: rst_usb_no, cause: rst_cause_o,
              pll: pll_rst_o, err: lock_err_o};
      if (first || cur !== prev) begin
        first = 1'b0;
        if (exp_q.size() == 0) begin
          check({phase, "_unexpected_change"}, 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check({phase, "_cycle"}, cyc, e.cyc);
          check({phase, "_value"}, 32'(cur), 32'(e.v));
        end
        prev = cur;
      end
    end
  end

  // Directed stimulus.
  initial begin
    int k;
    rst_i = 1'b1; pll_locked_i = 1'b1; ext_rst_req_i = 1'b0; jtag_srst_req_i = 1'b0;
    sw_rst_req_i = 1'b0; cause_clr_i = 1'b0;
    push(1, S_ASSERT, 1'b0, 1'b0, 1'b0);

    // Power-on: release reset with clean conditions.
    step(3);
    phase = "power_on";
    rst_i = 1'b0;
    seq_from(cyc, 1'b1);
    step(30);

    // Software reset pulse in RUN restarts the whole sequence.
    phase = "sw_pulse";
    sw_rst_req_i = 1'b1;
    exp_cause = exp_cause | 4'b0100;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(1);
    sw_rst_req_i = 1'b0;
    seq_from(cyc, 1'b1);
    step(30);

    // Cause clear in RUN.
    phase = "cause_clr";
    cause_clr_i = 1'b1;
    exp_cause = 4'b0000;
    push(cyc + 1, S_RUN, 1'b1, 1'b1, 1'b0);
    step(1);
    cause_clr_i = 1'b0;

    // JTAG request lands in HOLD with counter at 5, held for 10 cycles.
    phase = "jtag_hold";
    sw_rst_req_i = 1'b1;
    exp_cause = 4'b0100;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(1);
    sw_rst_req_i = 1'b0;
    push(cyc + 1, S_HOLD, 1'b0, 1'b0, 1'b0);
    step(11);
    jtag_srst_req_i = 1'b1;
    exp_cause = exp_cause | 4'b0010;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(10);
    jtag_srst_req_i = 1'b0;
    seq_from(cyc, 1'b1);
    step(30);

    // Lock loss while in REL_SYS.
    phase = "lock_rel_sys";
    sw_rst_req_i = 1'b1;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(1);
    sw_rst_req_i = 1'b0;
    seq_from(cyc, 1'b0);
    step(19);
    pll_locked_i = 1'b0;
    exp_cause = exp_cause | 4'b1000;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(3);
    pll_locked_i = 1'b1;
    seq_from(cyc, 1'b1);
    step(30);

    // Clear and external-request trip in the same cycle: set wins.
    phase = "clr_vs_ext";
    cause_clr_i   = 1'b1;
    ext_rst_req_i = 1'b1;
    exp_cause = 4'b0001;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(1);
    cause_clr_i = 1'b0;
    step(4);
    ext_rst_req_i = 1'b0;
    seq_from(cyc, 1'b1);
    step(30);

    // rst_i mid-run with a concurrent sw request: no cause logged.
    phase = "rst_mid";
    rst_i = 1'b1;
    sw_rst_req_i = 1'b1;
    exp_cause = 4'b0000;
    push(cyc + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
    step(1);
    sw_rst_req_i = 1'b0;
    step(1);
    rst_i = 1'b0;
    seq_from(cyc, 1'b1);
    step(30);

    // Lock held low in ASSERT for 70 cycles, then restored.
    phase = "lock_low";
    pll_locked_i = 1'b0;
    k = cyc;
    exp_cause = 4'b1000;
    push(k + 1, S_ASSERT, 1'b0, 1'b0, 1'b0);
`ifdef RSTSEQ_LOCK_WDOG_EN
    exp_err = 1'b1;
    push(k + 33, S_ASSERT, 1'b0, 1'b0, 1'b1);
    push(k + 37, S_ASSERT, 1'b0, 1'b0, 1'b0);
    push(k + 65, S_ASSERT, 1'b0, 1'b0, 1'b1);
    push(k + 69, S_ASSERT, 1'b0, 1'b0, 1'b0);
`endif
    step(70);
    pll_locked_i = 1'b1;
    seq_from(cyc, 1'b1);
    step(30);

    phase = "end";
    check("pending_events", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
